// File: rtl/qport_frontend.sv
// Board I/O front end: button sync/debounce, switch capture
// on write press, and a registered display channel mux.
module qport_btn_stage #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE) + 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable;
  logic                   stable_d;
  logic                   sync_q;

  assign sync_q = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '1;
      cnt      <= '0;
      stable   <= 1'b1;
      stable_d <= 1'b1;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], btn_n};
      stable_d <= stable;
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // released -> pressed only; releases are ignored
  assign press = stable_d & ~stable;
endmodule

module qport_frontend #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_write_n,
  input  logic                      btn_sel_n,
  input  logic [WIDTH-1:0]          sw_in,
  input  logic [CHANNELS*WIDTH-1:0] core_port_out,
  output logic                      core_port_write,
  output logic [WIDTH-1:0]          core_port_in,
  output logic [WIDTH-1:0]          disp_out,
  output logic [SEL_W-1:0]          disp_sel
);
  logic             wr_press;
  logic             sel_press;
  logic [WIDTH-1:0] sw_sync [SYNC_STAGES];
  logic [WIDTH-1:0] chan;

  qport_btn_stage #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_wr (
    .clk  (clk),
    .reset(reset),
    .btn_n(btn_write_n),
    .press(wr_press)
  );

  qport_btn_stage #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_sel (
    .clk  (clk),
    .reset(reset),
    .btn_n(btn_sel_n),
    .press(sel_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sw_sync[i] <= sw_sync[i-1];
    end
  end

  always_comb begin
    chan = core_port_out[WIDTH-1:0];
    for (int k = 1; k < CHANNELS; k++)
      if (disp_sel == SEL_W'(k))
        chan = core_port_out[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_port_write <= 1'b0;
      core_port_in    <= '0;
      disp_sel        <= '0;
      disp_out        <= '0;
    end else begin
      core_port_write <= wr_press;
      if (wr_press)
        core_port_in <= sw_sync[SYNC_STAGES-1];
      if (sel_press)
        disp_sel <= (disp_sel == SEL_W'(CHANNELS - 1))
                    ? '0 : disp_sel + 1'b1;
      disp_out <= chan;
    end
  end
endmodule

// File: tb/tb_qport_frontend.sv
// Random + directed bench for qport_frontend with a
// sample-window reference model and write/select scoreboards.
module tb_qport_frontend;
  localparam int W  = 16;
  localparam int CH = 3;
  localparam int S  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_write_n;
  logic          btn_sel_n;
  logic [W-1:0]  sw_in;
  logic [CH*W-1:0] cpo;
  logic          core_port_write;
  logic [W-1:0]  core_port_in;
  logic [W-1:0]  disp_out;
  logic [1:0]    disp_sel;

  qport_frontend #(
    .WIDTH(W), .CHANNELS(CH),
    .SYNC_STAGES(S), .DEBOUNCE(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_write_n(btn_write_n),
    .btn_sel_n(btn_sel_n),
    .sw_in(sw_in),
    .core_port_out(cpo),
    .core_port_write(core_port_write),
    .core_port_in(core_port_in),
    .disp_out(disp_out),
    .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [W-1:0] d;
  } wr_t;

  int total = 0;
  int bad   = 0;

  // reference model state
  int       cyc;
  bit       pw[$];
  bit       ps[$];
  logic [W-1:0] psw[$];
  bit       hw[$];
  bit       hs[$];
  bit       st_w, st_s;
  bit       pend_w, pend_s;
  int       m_sel;
  logic [W-1:0] m_cpi;
  logic [W-1:0] exp_disp;
  wr_t      wq[$];
  int       sq[$];
  bit       uw, us;
  logic [W-1:0] usw;

  // monitor bookkeeping
  int       first_wr;
  int       wr_count = 0;
  int       last_wr_cyc = -1;
  int       last_sel_cyc = -1;
  logic [1:0] last_sel;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    pw = {}; ps = {}; psw = {};
    for (int i = 0; i < S; i++) begin
      pw.push_back(1'b1);
      ps.push_back(1'b1);
      psw.push_back('0);
    end
    hw = {}; hs = {};
    st_w = 1'b1; st_s = 1'b1;
    pend_w = 1'b0; pend_s = 1'b0;
    m_sel = 0; m_cpi = '0; exp_disp = '0;
    wq = {}; sq = {};
    first_wr = -1;
    last_sel = '0;
  endtask

  // true when the last D delayed samples all disagree with st
  function automatic bit flips(input bit h[$], input bit st);
    if (h.size() < D) return 1'b0;
    for (int i = h.size() - D; i < h.size(); i++)
      if (h[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) begin
      cyc++;
      uw  = pw.pop_front();  pw.push_back(btn_write_n);
      us  = ps.pop_front();  ps.push_back(btn_sel_n);
      usw = psw.pop_front(); psw.push_back(sw_in);
      exp_disp = cpo[m_sel*W +: W];
      if (pend_w) begin
        m_cpi = usw;
        wq.push_back('{cyc, usw});
      end
      if (pend_s) begin
        m_sel = (m_sel + 1) % CH;
        sq.push_back(m_sel);
      end
      pend_w = 1'b0;
      pend_s = 1'b0;
      hw.push_back(uw);
      if (hw.size() > D) void'(hw.pop_front());
      hs.push_back(us);
      if (hs.size() > D) void'(hs.pop_front());
      if (flips(hw, st_w)) begin
        st_w = ~st_w;
        hw = {};
        pend_w = (st_w == 1'b0);
      end
      if (flips(hs, st_s)) begin
        st_s = ~st_s;
        hs = {};
        pend_s = (st_s == 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_write", {31'd0, core_port_write}, 0);
      chk("rst_cpi", {16'd0, core_port_in}, 0);
      chk("rst_sel", {30'd0, disp_sel}, 0);
      chk("rst_disp", {16'd0, disp_out}, 0);
    end else begin
      if (core_port_write) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (first_wr < 0) first_wr = cyc;
        if (wq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_data", {16'd0, core_port_in}, {16'd0, e.d});
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk("wr_missing", 0, 1);
        void'(wq.pop_front());
      end
      if (disp_sel != last_sel) begin
        last_sel_cyc = cyc;
        if (sq.size() == 0) chk("sel_unexpected", 1, 0);
        else chk("sel_step", {30'd0, disp_sel}, sq.pop_front());
      end
      last_sel = disp_sel;
      chk("sel_now", {30'd0, disp_sel}, m_sel);
      chk("disp_now", {16'd0, disp_out}, {16'd0, exp_disp});
      chk("cpi_hold", {16'd0, core_port_in}, {16'd0, m_cpi});
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_sel();
    btn_sel_n = 1'b0;
    cyc_n(8);
    btn_sel_n = 1'b1;
    cyc_n(8);
  endtask

  int cw, cs, n0;

  initial begin
    model_reset();
    reset = 1'b0;
    btn_write_n = 1'b1;
    btn_sel_n = 1'b1;
    sw_in = '0;
    cpo = '0;
    cyc_n(3);

    // clean press, timing from reset release
    reset = 1'b1;
    sw_in = 16'h00A5;
    btn_write_n = 1'b0;
    cyc_n(100);
    chk("first_wr_edge", first_wr, 7);
    chk("one_pulse", wr_count, 1);
    chk("cap_a5", {16'd0, core_port_in}, 32'h00A5);
    btn_write_n = 1'b1;
    cyc_n(10);

    // short glitch then bounce
    n0 = wr_count;
    btn_write_n = 1'b0;
    cyc_n(3);
    btn_write_n = 1'b1;
    cyc_n(10);
    chk("glitch_ignored", wr_count, n0);
    for (int i = 0; i < 4; i++) begin
      btn_write_n = i[0];
      cyc_n(1);
    end
    btn_write_n = 1'b0;
    cyc_n(20);
    btn_write_n = 1'b1;
    cyc_n(10);
    chk("bounce_one", wr_count, n0 + 1);

    // select wrap across three channels
    cpo = {16'h3333, 16'h2222, 16'h1111};
    cyc_n(2);
    press_sel();
    chk("wrap_sel1", {30'd0, disp_sel}, 1);
    chk("wrap_disp1", {16'd0, disp_out}, 32'h2222);
    press_sel();
    chk("wrap_sel2", {30'd0, disp_sel}, 2);
    chk("wrap_disp2", {16'd0, disp_out}, 32'h3333);
    press_sel();
    chk("wrap_sel0", {30'd0, disp_sel}, 0);
    chk("wrap_disp0", {16'd0, disp_out}, 32'h1111);

    // simultaneous presses
    btn_write_n = 1'b0;
    btn_sel_n = 1'b0;
    cyc_n(12);
    btn_write_n = 1'b1;
    btn_sel_n = 1'b1;
    cyc_n(10);
    chk("simul_cycle", last_wr_cyc, last_sel_cyc);

    // switch changes after capture stay invisible
    sw_in = 16'hFFFF;
    cyc_n(10);
    chk("cpi_unchanged", {16'd0, core_port_in}, 32'h00A5);

    // async reset in the middle of a write pulse
    btn_write_n = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("pulse_seen", {31'd0, core_port_write}, 1);
    reset = 1'b0;
    #1;
    chk("async_write", {31'd0, core_port_write}, 0);
    chk("async_cpi", {16'd0, core_port_in}, 0);
    chk("async_sel", {30'd0, disp_sel}, 0);
    chk("async_disp", {16'd0, disp_out}, 0);
    btn_write_n = 1'b1;
    btn_sel_n = 1'b0;
    cyc_n(4);

    // select held through reset release
    reset = 1'b1;
    cyc_n(30);
    chk("hold_reset_sel", {30'd0, disp_sel}, 1);
    chk("hold_reset_nowr", {31'd0, core_port_write}, 0);
    btn_sel_n = 1'b1;
    cyc_n(10);

    // randomized runs of button levels, switches and channels
    cw = 0;
    cs = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cw == 0) begin
        btn_write_n = 1'($urandom_range(0, 1));
        cw = $urandom_range(1, 9);
      end
      if (cs == 0) begin
        btn_sel_n = 1'($urandom_range(0, 1));
        cs = $urandom_range(1, 9);
      end
      cw--;
      cs--;
      sw_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        cpo = {16'($urandom), 16'($urandom), 16'($urandom)};
      cyc_n(1);
    end
    btn_write_n = 1'b1;
    btn_sel_n = 1'b1;
    cyc_n(20);
    chk("wq_drained", wq.size(), 0);
    chk("sq_drained", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
